// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32I pipeline stages.
package pipeline_pkg;

  // Writeback result source selector.
  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10,
    RES_RSVD = 2'b11
  } result_src_e;

  // Load size/sign field encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // MEM/WB pipeline register contents.
  typedef struct packed {
    logic        valid;
    logic        regwrite;
    result_src_e result_src;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus4;
  } memwb_t;

endpackage : pipeline_pkg

// File: rtl/load_extend.sv
// Extracts the addressed byte/half from a loaded word and extends it.
module load_extend
  import pipeline_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_word,
  output logic [31:0] o_value
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the byte addressed by the low address bits.
  always_comb begin
    w_byte = i_word[7:0];
    case (i_addr)
      2'd0: w_byte = i_word[7:0];
      2'd1: w_byte = i_word[15:8];
      2'd2: w_byte = i_word[23:16];
      2'd3: w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
  end

  // Select the half by addr[1]; addr[0] is ignored (no misalignment check).
  always_comb begin
    w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
  end

  // Extend according to the load type; unknown codes pass the word through.
  always_comb begin
    o_value = i_word;
    case (i_funct3)
      F3_LB:   o_value = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_value = {24'h0, w_byte};
      F3_LH:   o_value = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_value = {16'h0, w_half};
      F3_LW:   o_value = i_word;
      default: o_value = i_word;
    endcase
  end

endmodule : load_extend

// File: rtl/writeback_stage.sv
// W stage: MEM/WB register, result selection, and retire/cycle counters.
module writeback_stage
  import pipeline_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallW,
  input  logic             FlushW,
  input  logic             ValidM,
  input  logic             RegWriteM,
  input  logic [1:0]       ResultSrcM,
  input  logic [2:0]       Funct3M,
  input  logic [4:0]       RdM,
  input  logic [31:0]      ALUResultM,
  input  logic [31:0]      ReadDataM,
  input  logic [31:0]      PCPlus4M,
  output logic             ValidW,
  output logic             RegWriteW,
  output logic [4:0]       RdW,
  output logic [31:0]      ResultW,
  output logic [CNT_W-1:0] InstRetW,
  output logic [CNT_W-1:0] CycleW
);

  memwb_t           r_memwb;
  logic [CNT_W-1:0] r_instret;
  logic [CNT_W-1:0] r_cycle;
  memwb_t           w_capture;
  logic [31:0]      w_load_value;
  logic             w_retire;

  // Pack the M-stage inputs into the register bundle.
  always_comb begin
    w_capture            = '0;
    w_capture.valid      = ValidM;
    w_capture.regwrite   = RegWriteM;
    w_capture.result_src = result_src_e'(ResultSrcM);
    w_capture.funct3     = Funct3M;
    w_capture.rd         = RdM;
    w_capture.alu_result = ALUResultM;
    w_capture.read_data  = ReadDataM;
    w_capture.pc_plus4   = PCPlus4M;
  end

  // MEM/WB register: flush beats stall, otherwise capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_memwb <= '0;
    end else if (FlushW) begin
      r_memwb <= '0;
    end else if (!StallW) begin
      r_memwb <= w_capture;
    end
  end

  // The held instruction leaves W when the register is not held (or is flushed).
  always_comb begin
    w_retire = r_memwb.valid & (~StallW | FlushW);
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_instret <= '0;
    end else if (w_retire) begin
      r_instret <= r_instret + CNT_W'(1);
    end
  end

  // Free-running cycle counter since reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + CNT_W'(1);
    end
  end

  load_extend u_load_extend (
    .i_funct3 (r_memwb.funct3),
    .i_addr   (r_memwb.alu_result[1:0]),
    .i_word   (r_memwb.read_data),
    .o_value  (w_load_value)
  );

  // Result mux driven only by registered fields.
  always_comb begin
    ResultW = 32'h0;
    case (r_memwb.result_src)
      RES_ALU:  ResultW = r_memwb.alu_result;
      RES_MEM:  ResultW = w_load_value;
      RES_PC4:  ResultW = r_memwb.pc_plus4;
      RES_RSVD: ResultW = 32'h0;
      default:  ResultW = 32'h0;
    endcase
  end

  // Register-file write port; x0 writes are suppressed.
  always_comb begin
    ValidW    = r_memwb.valid;
    RegWriteW = r_memwb.regwrite & r_memwb.valid & (r_memwb.rd != 5'd0);
    RdW       = r_memwb.rd;
    InstRetW  = r_instret;
    CycleW    = r_cycle;
  end

endmodule : writeback_stage

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Final (W) stage of the 5-stage RV32I pipeline. It captures the M-stage bundle in the MEM/WB pipeline register and selects the writeback result. For loads it extracts and sign- or zero-extends the loaded value. It drives the register-file write port (RegWriteW, RdW, ResultW) consumed by the decode stage, and keeps the retired-instruction and cycle counters.

Parameters:
CNT_W, 64, width of the InstRetW and CycleW counters (legal range 32..64)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
StallW  input  1  hold the MEM/WB register
FlushW  input  1  load a bubble into the MEM/WB register
ValidM  input  1  M stage holds a real instruction
RegWriteM  input  1  instruction writes rd
ResultSrcM  input  2  00 ALU, 01 load data, 10 PC+4, 11 reserved
Funct3M  input  3  load size/sign field
RdM  input  5  destination register
ALUResultM  input  32  ALU result / load address
ReadDataM  input  32  raw 32-bit word from data memory
PCPlus4M  input  32  link value
ValidW  output  1  W holds a real instruction
RegWriteW  output  1  register-file write enable
RdW  output  5  register-file write address
ResultW  output  32  register-file write data
InstRetW  output  CNT_W  retired-instruction count
CycleW  output  CNT_W  cycles since reset release

Behaviour:
- Reset (rst=0, asynchronous): MEM/WB register fields, InstRetW and CycleW all clear to 0. Outputs are therefore ValidW=0, RegWriteW=0, RdW=0 and ResultW=0. Reset asserted mid-operation discards the held instruction with no write.
- MEM/WB register update on each rising edge:
  - FlushW=1: load a bubble (valid=0, regwrite=0, all other fields 0). Flush has priority over stall.
  - else StallW=1: hold all fields.
  - else: capture all M inputs.
- Latency: one cycle from M inputs to W outputs. ResultW, RegWriteW and RdW are combinational from registered fields only, with no combinational path from M inputs.
- RegWriteW = reg.regwrite & reg.valid & (reg.rd != 0). Writes to x0 are suppressed. RdW always reflects reg.rd.
- Result mux on registered ResultSrc:
  - 00: ALUResult.
  - 01: extracted load data.
  - 10: PCPlus4.
  - 11: 32'h0, with the write still governed by regwrite.
- Load extraction (a = registered ALUResult[1:0], w = registered ReadData):
  - funct3 000 LB: byte w[8a+7:8a], sign-extended.
  - 100 LBU: the same byte, zero-extended.
  - 001 LH: half selected by a[1], sign-extended; a[0] ignored.
  - 101 LHU: the same half, zero-extended.
  - 010 LW and all other codes: w unchanged.
  - Misalignment is not detected here.
- CycleW: increments by 1 every rising edge while rst=1 and wraps modulo 2^CNT_W.
- InstRetW:
  - Increments by 1 on a rising edge where ValidW=1 and (StallW=0 or FlushW=1), i.e. the instruction leaves W.
  - A stalled instruction is counted once. Bubbles are never counted.
  - Wraps modulo 2^CNT_W.
- Simultaneous StallW=1 and FlushW=1: flush wins. The outgoing valid instruction is counted as retired; its register write already occurred during the cycle it was presented.
- ValidW = reg.valid.

Decomposition:
- Shared package (pipeline_pkg):
  - ResultSrc encoding as a 2-bit enum (RES_ALU, RES_MEM, RES_PC4, RES_RSVD).
  - Load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
  - MEM/WB bundle struct.
- One combinational sub-module, load_extend (inputs funct3, addr[1:0], word; output 32-bit value), reused by any future load path.
- Counters and the pipeline register stay in writeback_stage.

Test Plan:
1. Reset, then release and apply 10 idle cycles (ValidM=0) -> all outputs 0 during reset; CycleW=10 and InstRetW=0 after.
2. ALU op: ValidM=1, RegWriteM=1, ResultSrc=00, RdM=5, ALUResult=32'h1234_5678 -> next cycle RegWriteW=1, RdW=5, ResultW=32'h1234_5678; InstRetW=1 one edge later.
3. Loads with ReadData=32'h8081_F27F:
   - LB, addr 3 -> 32'hFFFF_FF80.
   - LBU, addr 3 -> 32'h0000_0080.
   - LH, addr 2 -> 32'hFFFF_8081.
   - LHU, addr 0 -> 32'h0000_F27F.
   - LW -> 32'h8081_F27F.
4. JAL with RdM=0, ResultSrc=10, PCPlus4=32'h0000_0104 -> ResultW=32'h104, RegWriteW=0, ValidW=1; InstRetW increments.
5. Stall held 3 cycles on a valid instruction, then released -> W outputs constant throughout; InstRetW increments exactly once. FlushW with StallW both high -> next cycle ValidW=0, RegWriteW=0.
6. Assert rst low asynchronously mid-cycle while ValidW=1 and RegWriteW=1 -> RegWriteW drops to 0 immediately; both counters read 0.
